// File: rtl/cv32e40p_wake_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_wake_ctrl
//  Purpose  : Cluster-side wake controller for the CV32E40P sleep unit.
//             Observes core_sleep_i, drives the core clock enable, buffers
//             cluster events and gates irq/debug towards the core while its
//             clock is off or still coming back up.
//  Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_wake_ctrl #(
    parameter int NUM_EVT    = 8,   // number of event lines (1..32)
    parameter int WAKE_DELAY = 2    // clock-on cycles before irq/debug resume (0..15)
) (
    input  logic                clk_ungated_i,
    input  logic                rst_n,

    input  logic                core_sleep_i,
    input  logic [NUM_EVT-1:0]  evt_i,
    input  logic [NUM_EVT-1:0]  evt_mask_i,
    input  logic [NUM_EVT-1:0]  evt_clr_i,
    input  logic [31:0]         irq_i,
    input  logic                debug_req_i,

    output logic                pulp_clock_en_o,
    output logic [31:0]         irq_o,
    output logic                debug_req_o,
    output logic [NUM_EVT-1:0]  evt_buf_o,
    output logic                evt_pending_o,
    output logic [31:0]         sleep_cnt_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          CNT_W     = 4;
    localparam logic [3:0]  WAKE_LOAD = 4'(WAKE_DELAY);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_ACTIVE     = 2'd0,
        ST_SLEEP_PEND = 2'd1,
        ST_SLEEP      = 2'd2,
        ST_WAKE       = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e               state_q,     state_d;
    logic [CNT_W-1:0]     wake_cnt_q,  wake_cnt_d;
    logic [NUM_EVT-1:0]   evt_buf_q,   evt_buf_d;
    logic [31:0]          sleep_cnt_q, sleep_cnt_d;

    logic                 wake;
    logic                 fwd_en;

    // ------------------------------------------------------------------------
    // Event buffer: a new event in the same cycle as its clear must survive,
    // so the set term is ORed in after the clear mask.
    // ------------------------------------------------------------------------
    always_comb begin
        evt_buf_d = (evt_buf_q & ~evt_clr_i) | evt_i;
    end

    // Wake looks at the next buffer value so a same-cycle event blocks sleep.
    always_comb begin
        wake = (|(evt_buf_d & evt_mask_i)) | (|irq_i) | debug_req_i;
    end

    // ------------------------------------------------------------------------
    // Next-state and wake-delay counter
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (core_sleep_i && !wake) begin
                    state_d = ST_SLEEP_PEND;
                end
            end
            ST_SLEEP_PEND: begin
                // A second quiet cycle is needed before the clock is cut,
                // giving the core one cycle to retract its request.
                if (core_sleep_i && !wake) begin
                    state_d = ST_SLEEP;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_SLEEP: begin
                if (wake || !core_sleep_i) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Counter value 0 is the final WAKE cycle, so WAKE lasts
                // WAKE_DELAY+1 cycles with the clock already running.
                if (wake_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // Saturating count of cycles spent with the core clock off.
    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        if ((state_q == ST_SLEEP) && (sleep_cnt_q != CNT_MAX)) begin
            sleep_cnt_d = sleep_cnt_q + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACTIVE;
            wake_cnt_q  <= '0;
            evt_buf_q   <= '0;
            sleep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            evt_buf_q   <= evt_buf_d;
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The clock enable and the irq/debug gate are pure decodes of
    // the state register, so a disabled clock always implies gated requests
    // and reset (state forced to ACTIVE) gives pass-through immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        fwd_en          = (state_q == ST_ACTIVE) || (state_q == ST_SLEEP_PEND);
        pulp_clock_en_o = (state_q != ST_SLEEP);
        irq_o           = fwd_en ? irq_i : 32'd0;
        debug_req_o     = fwd_en & debug_req_i;
        evt_buf_o       = evt_buf_q;
        evt_pending_o   = |(evt_buf_q & evt_mask_i);
        sleep_cnt_o     = sleep_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_wake_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cv32e40p_wake_ctrl
//  Purpose  : Self-checking bench for cv32e40p_wake_ctrl. Directed scenarios
//             plus randomized traffic, all compared every cycle against a
//             behavioural model of the sleep/wake rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_wake_ctrl;

    localparam int NE = 8;
    localparam int WD = 2;

    logic            clk_ungated_i = 1'b0;
    logic            rst_n         = 1'b1;
    logic            core_sleep_i  = 1'b0;
    logic [NE-1:0]   evt_i         = '0;
    logic [NE-1:0]   evt_mask_i    = '0;
    logic [NE-1:0]   evt_clr_i     = '0;
    logic [31:0]     irq_i         = '0;
    logic            debug_req_i   = 1'b0;

    logic            pulp_clock_en_o;
    logic [31:0]     irq_o;
    logic            debug_req_o;
    logic [NE-1:0]   evt_buf_o;
    logic            evt_pending_o;
    logic [31:0]     sleep_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: clock-off flag, remaining wake cycles (-1 = none),
    // whether the previous cycle already was a quiet sleep request.
    bit              m_asleep;
    int              m_wake_rem;
    bit              m_quiet_seen;
    logic [NE-1:0]   m_buf;
    logic [31:0]     m_cnt;

    cv32e40p_wake_ctrl #(
        .NUM_EVT    (NE),
        .WAKE_DELAY (WD)
    ) u_dut (
        .clk_ungated_i   (clk_ungated_i),
        .rst_n           (rst_n),
        .core_sleep_i    (core_sleep_i),
        .evt_i           (evt_i),
        .evt_mask_i      (evt_mask_i),
        .evt_clr_i       (evt_clr_i),
        .irq_i           (irq_i),
        .debug_req_i     (debug_req_i),
        .pulp_clock_en_o (pulp_clock_en_o),
        .irq_o           (irq_o),
        .debug_req_o     (debug_req_o),
        .evt_buf_o       (evt_buf_o),
        .evt_pending_o   (evt_pending_o),
        .sleep_cnt_o     (sleep_cnt_o)
    );

    always #5 clk_ungated_i = ~clk_ungated_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_asleep     = 1'b0;
        m_wake_rem   = -1;
        m_quiet_seen = 1'b0;
        m_buf        = '0;
        m_cnt        = '0;
    endtask

    // One clock edge of the reference behaviour, using the current inputs.
    task automatic model_step();
        logic [NE-1:0] nb;
        bit            wk;
        nb = (m_buf & ~evt_clr_i) | evt_i;
        wk = ((nb & evt_mask_i) != '0) || (irq_i != 32'd0) || debug_req_i;
        if (m_asleep && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_asleep) begin
            if (wk || !core_sleep_i) begin
                m_asleep   = 1'b0;
                m_wake_rem = WD;
            end
        end else if (m_wake_rem >= 0) begin
            m_wake_rem = m_wake_rem - 1;
        end else if (core_sleep_i && !wk) begin
            if (m_quiet_seen) begin
                m_asleep     = 1'b1;
                m_quiet_seen = 1'b0;
            end else begin
                m_quiet_seen = 1'b1;
            end
        end else begin
            m_quiet_seen = 1'b0;
        end
        m_buf = nb;
    endtask

    task automatic compare_all();
        bit fwd;
        fwd = !m_asleep && (m_wake_rem < 0);
        check_val("clock_en",  32'(pulp_clock_en_o), 32'(!m_asleep));
        check_val("irq_o",     irq_o,                fwd ? irq_i : 32'd0);
        check_val("debug_o",   32'(debug_req_o),     32'(fwd && debug_req_i));
        check_val("evt_buf",   32'(evt_buf_o),       32'(m_buf));
        check_val("pending",   32'(evt_pending_o),   32'((m_buf & evt_mask_i) != '0));
        check_val("sleep_cnt", sleep_cnt_o,          m_cnt);
    endtask

    // Apply inputs, clock once, then compare on the falling edge.
    task automatic step(input logic slp, input logic [NE-1:0] ev, input logic [NE-1:0] msk,
                        input logic [NE-1:0] clr, input logic [31:0] irq, input logic dbg);
        core_sleep_i = slp;
        evt_i        = ev;
        evt_mask_i   = msk;
        evt_clr_i    = clr;
        irq_i        = irq;
        debug_req_i  = dbg;
        @(posedge clk_ungated_i);
        model_step();
        @(negedge clk_ungated_i);
        compare_all();
    endtask

    // Asynchronous reset: outputs must react before any clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_clock_en",  32'(pulp_clock_en_o), 32'd1);
        check_val("rst_evt_buf",   32'(evt_buf_o),       32'd0);
        check_val("rst_sleep_cnt", sleep_cnt_o,          32'd0);
        check_val("rst_irq_pass",  irq_o,                irq_i);
        @(posedge clk_ungated_i);
        @(negedge clk_ungated_i);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [NE-1:0] ev, clr, msk, one;
        logic [31:0]   irq;
        logic          slp, dbg;

        model_reset();
        #2;
        apply_reset();

        // Quiet sleep request: pending at cycle 1, clock off from cycle 2.
        step(1'b1, '0, '0, '0, 32'd0, 1'b0);
        check_val("entry_c1_clk_en", 32'(pulp_clock_en_o), 32'd1);
        step(1'b1, '0, '0, '0, 32'd0, 1'b0);
        check_val("entry_c2_clk_en", 32'(pulp_clock_en_o), 32'd0);
        step(1'b1, '0, '0, '0, 32'd0, 1'b0);
        step(1'b1, '0, '0, '0, 32'd0, 1'b0);
        check_val("sleep_cnt_2", sleep_cnt_o, 32'd2);

        // Masked event wakes: clock on next cycle, irq held off during WAKE.
        step(1'b1, 8'h01, 8'h01, '0, 32'h80, 1'b0);
        check_val("wake_clk_en", 32'(pulp_clock_en_o), 32'd1);
        check_val("wake_irq_gated", irq_o, 32'd0);
        step(1'b1, '0, 8'h01, '0, 32'h80, 1'b0);
        step(1'b1, '0, 8'h01, '0, 32'h80, 1'b0);
        check_val("wake_irq_gated3", irq_o, 32'd0);
        step(1'b1, '0, 8'h01, '0, 32'h80, 1'b0);
        check_val("active_irq_pass", irq_o, 32'h80);
        check_val("still_pending", 32'(evt_pending_o), 32'd1);
        step(1'b0, '0, 8'h01, 8'h01, 32'd0, 1'b0);
        check_val("cleared_pending", 32'(evt_pending_o), 32'd0);

        // Event in the same cycle as the sleep request blocks entry.
        step(1'b1, 8'h04, 8'h04, '0, 32'd0, 1'b0);
        step(1'b1, '0, 8'h04, '0, 32'd0, 1'b0);
        step(1'b1, '0, 8'h04, '0, 32'd0, 1'b0);
        check_val("blocked_clk_en", 32'(pulp_clock_en_o), 32'd1);
        step(1'b0, '0, 8'h04, 8'h04, 32'd0, 1'b0);

        // Set wins over clear in the same cycle.
        step(1'b0, 8'h08, '0, 8'h08, 32'd0, 1'b0);
        check_val("set_wins", 32'(evt_buf_o[3]), 32'd1);
        step(1'b0, '0, '0, 8'h08, 32'd0, 1'b0);
        check_val("clr_alone", 32'(evt_buf_o[3]), 32'd0);

        // Debug wake from sleep, then reset mid-sleep.
        for (int i = 0; i < 4; i++) step(1'b1, '0, '0, '0, 32'd0, 1'b0);
        step(1'b1, '0, '0, '0, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, '0, '0, '0, 32'd0, 1'b0);
        apply_reset();

        // Randomized traffic, biased towards long quiet sleep requests.
        slp = 1'b0;
        msk = 8'h0F;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) slp = ~slp;
            if ($urandom_range(63) == 0) msk = NE'($urandom & $urandom);
            one = NE'(1) << $urandom_range(NE - 1);
            ev  = ($urandom_range(5) == 0) ? one : '0;
            clr = ($urandom_range(3) == 0) ? NE'($urandom) : '0;
            irq = ($urandom_range(23) == 0) ? (32'd1 << $urandom_range(31)) : 32'd0;
            dbg = ($urandom_range(39) == 0);
            step(slp, ev, msk, clr, irq, dbg);
            if ($urandom_range(499) == 0) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv32e40p_wake_ctrl.md
CV32E40P_WAKE_CTRL -- requirements
Module: cv32e40p_wake_ctrl

Cluster-side counterpart of the core sleep unit. It observes core_sleep, drives pulp_clock_en and gates irq/debug to the core while its clock is off.

Interface
REQ-001 Parameter NUM_EVT, default 8, number of event lines (1..32).
REQ-002 Parameter WAKE_DELAY, default 2, clock-on cycles before irq/debug forwarding resumes (0..15).
REQ-003 clk_ungated_i  input  1  free-running clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 core_sleep_i  input  1  sleep request from the core (p.elw blocked, core idle).
REQ-006 evt_i  input  NUM_EVT  single-cycle event pulses.
REQ-007 evt_mask_i  input  NUM_EVT  per-event enable for wake and pending.
REQ-008 evt_clr_i  input  NUM_EVT  write-1-to-clear of buffered events.
REQ-009 irq_i  input  32  raw interrupt lines.
REQ-010 debug_req_i  input  1  raw debug request.
REQ-011 pulp_clock_en_o  output  1  core clock enable, registered.
REQ-012 irq_o  output  32  gated interrupts to the core.
REQ-013 debug_req_o  output  1  gated debug request to the core.
REQ-014 evt_buf_o  output  NUM_EVT  buffered event bits.
REQ-015 evt_pending_o  output  1  |(evt_buf & evt_mask_i).
REQ-016 sleep_cnt_o  output  32  total cycles spent in SLEEP, saturating.

Function
REQ-017 FSM states: ACTIVE, SLEEP_PEND, SLEEP, WAKE.
REQ-018 Event buffer bit k is set when evt_i[k]=1 and cleared when evt_clr_i[k]=1; if both occur in the same cycle, set wins.
REQ-019 wake = evt_pending (using the next buffer value, i.e. including same-cycle evt_i) | (|irq_i) | debug_req_i.
REQ-020 ACTIVE -> SLEEP_PEND when core_sleep_i=1 and wake=0; otherwise stay in ACTIVE.
REQ-021 SLEEP_PEND -> SLEEP when core_sleep_i=1 and wake=0; -> ACTIVE when core_sleep_i=0 or wake=1.
REQ-022 SLEEP -> WAKE when wake=1 or core_sleep_i=0; on that transition the wake counter loads WAKE_DELAY.
REQ-023 WAKE decrements the counter each cycle and moves to ACTIVE in the cycle the counter is 0; with WAKE_DELAY=0, WAKE lasts exactly 1 cycle.
REQ-024 pulp_clock_en_o is 0 only while the state is SLEEP, and is derived directly from the state register.
REQ-025 irq_o=irq_i and debug_req_o=debug_req_i in ACTIVE and SLEEP_PEND; both are 0 in SLEEP and WAKE.
REQ-026 Consequence of REQ-024/025: pulp_clock_en_o=0 always implies irq_o=0 and debug_req_o=0.
REQ-027 Minimum sleep entry latency: 2 cycles from core_sleep_i rising to pulp_clock_en_o=0.
REQ-028 Wake latency: pulp_clock_en_o=1 in the cycle after wake is sampled in SLEEP.
REQ-029 sleep_cnt_o increments by 1 each cycle the state is SLEEP and holds at 0xFFFFFFFF.
REQ-030 Changes to evt_mask_i take effect combinationally on evt_pending_o and wake.

Reset
REQ-031 On rst_n=0, asynchronously: state=ACTIVE, pulp_clock_en_o=1, evt_buf_o=0, wake counter=0, sleep_cnt_o=0.
REQ-032 During reset, irq_o and debug_req_o follow REQ-025 for ACTIVE (pass-through).
REQ-033 Reset asserted in any state, including SLEEP or WAKE, returns the block to ACTIVE with the clock enabled; no partial sequence resumes.

Verification
REQ-034 Reset, then core_sleep_i=1, no events -> SLEEP_PEND at cycle 1, pulp_clock_en_o=0 from cycle 2, sleep_cnt_o counts 1,2,3...
REQ-035 In SLEEP with evt_mask_i=0x01, pulse evt_i=0x01 -> pulp_clock_en_o=1 next cycle, irq_o=0 for 3 cycles (WAKE_DELAY=2), then ACTIVE; evt_pending_o=1 until evt_clr_i=0x01.
REQ-036 evt_i=0x04 (masked in) in the same cycle core_sleep_i rises -> state stays ACTIVE and pulp_clock_en_o never drops.
REQ-037 evt_i[3] and evt_clr_i[3] in the same cycle -> evt_buf_o[3]=1; evt_clr_i[3] alone next cycle -> evt_buf_o[3]=0.
REQ-038 irq_i=0x80 asserted in SLEEP -> irq_o=0 while pulp_clock_en_o=0 and in WAKE; irq_o=0x80 on ACTIVE entry.
REQ-039 rst_n pulsed low mid-SLEEP -> pulp_clock_en_o=1 immediately (asynchronously), evt_buf_o=0, sleep_cnt_o=0.
